// File: rtl/dmem_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WAIT_CNT_W = 4;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage: synchronous write, synchronous enabled read, no reset.
module dmem_array #(
    parameter int DEPTH = 64,
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             we,
    input  logic             re,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem_q[idx] <= wdata;
        if (re) rdata_q <= mem_q[idx];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder for the MEM stage (IDLE -> BUSY -> DONE handshake).
// Optional load/store performance counters are enabled by defining DMEM_PERF_CNT_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memreq,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        memready,
    output logic        memstall,
    output logic        misaligned,
    output logic [31:0] rdcount,
    output logic [31:0] wrcount
);

    localparam int                    IDX_W = clog2(DEPTH);
    localparam logic [WAIT_CNT_W-1:0] WS    = WAIT_CNT_W'(WAIT_STATES);

    state_t                  state_q, state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic                    wr_q;
    logic [IDX_W+1:0]        addr_q;
    logic [31:0]             wdata_q;
    logic                    rdvalid_q;

    logic                    accept, enter_done;
    logic                    acc_wr, acc_aligned;
    logic [IDX_W+1:0]        acc_addr;
    logic [31:0]             acc_wdata;
    logic [31:0]             arr_rdata;
    logic                    unused_addr;

    assign unused_addr = ^addr[31:IDX_W+2];
    assign accept      = (state_q == IDLE) && memreq;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (memreq) begin
                    cnt_d   = WS;
                    state_d = (WS == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == WAIT_CNT_W'(1)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The access happens on the edge entering DONE; with zero wait states that
    // is the accepting edge itself, so the live inputs are used instead of the latches.
    assign enter_done  = (state_d == DONE);
    assign acc_wr      = accept ? memwrite : wr_q;
    assign acc_addr    = accept ? addr[IDX_W+1:0] : addr_q;
    assign acc_wdata   = accept ? writedata : wdata_q;
    assign acc_aligned = (acc_addr[1:0] == 2'b00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdvalid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                wr_q    <= memwrite;
                addr_q  <= addr[IDX_W+1:0];
                wdata_q <= writedata;
            end
            if (enter_done && !acc_wr) rdvalid_q <= acc_aligned;
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (enter_done && acc_wr && acc_aligned),
        .re    (enter_done && !acc_wr && acc_aligned),
        .idx   (acc_addr[IDX_W+1:2]),
        .wdata (acc_wdata),
        .rdata (arr_rdata)
    );

    // A misaligned load clears rdvalid so the held array word is masked to 0.
    assign readdata   = rdvalid_q ? arr_rdata : 32'd0;
    assign memready   = (state_q == DONE);
    assign memstall   = accept || (state_q == BUSY);
    assign misaligned = (state_q == DONE) && (addr_q[1:0] != 2'b00);

`ifdef DMEM_PERF_CNT_EN
    logic [31:0] rdcount_q, wrcount_q;
    logic        done_aligned;

    assign done_aligned = (state_q == DONE) && (addr_q[1:0] == 2'b00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdcount_q <= '0;
            wrcount_q <= '0;
        end else if (done_aligned) begin
            if (wr_q) wrcount_q <= wrcount_q + 32'd1;
            else      rdcount_q <= rdcount_q + 32'd1;
        end
    end

    assign rdcount = rdcount_q;
    assign wrcount = wrcount_q;
`else
    assign rdcount = 32'd0;
    assign wrcount = 32'd0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed table, hand sequences and random traffic
// against a word-array reference model, on a 2-wait-state and a 0-wait-state instance.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [2];
    logic        req [2];
    logic        wr  [2];
    logic [31:0] ad  [2];
    logic [31:0] wd  [2];
    logic [31:0] rd  [2];
    logic [31:0] rc  [2];
    logic [31:0] wc  [2];
    logic        rdy [2];
    logic        stl [2];
    logic        mis [2];

    dmem_responder #(.DEPTH(64), .WAIT_STATES(2)) u_ws2 (
        .clk(clk), .reset(rst[0]), .memreq(req[0]), .memwrite(wr[0]), .addr(ad[0]),
        .writedata(wd[0]), .readdata(rd[0]), .memready(rdy[0]), .memstall(stl[0]),
        .misaligned(mis[0]), .rdcount(rc[0]), .wrcount(wc[0]));

    dmem_responder #(.DEPTH(64), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .reset(rst[1]), .memreq(req[1]), .memwrite(wr[1]), .addr(ad[1]),
        .writedata(wd[1]), .readdata(rd[1]), .memready(rdy[1]), .memstall(stl[1]),
        .misaligned(mis[1]), .rdcount(rc[1]), .wrcount(wc[1]));

    // Reference model: word array per instance, with a known-bit per word.
    logic [31:0] m_mem   [2][64];
    bit          m_known [2][64];
    logic [31:0] m_rd    [2];
    bit          m_rdk   [2];
    int          m_rc    [2];
    int          m_wc    [2];

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        bit          ck;
        logic [31:0] er;
        bit          em;
    } vec_t;

    vec_t tbl [9];

    function automatic logic [31:0] ecnt(input int v);
`ifdef DMEM_PERF_CNT_EN
        return 32'(v);
`else
        return (v < 0) ? 32'd1 : 32'd0;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset(input int s);
        rst[s] = 1'b1;
        req[s] = 1'b0;
        @(posedge clk); #1;
        rst[s] = 1'b0;
        m_rc[s]  = 0;
        m_wc[s]  = 0;
        m_rd[s]  = 32'd0;
        m_rdk[s] = 1'b1;
    endtask

    // One full handshake; starts and ends just after a rising edge with the FSM idle.
    task automatic op(input int s, input bit w, input logic [31:0] a, input logic [31:0] d,
                      input bit drop, output logic [31:0] r, output bit mi);
        int lat, st, idx, exp_lat;
        bit ok, mal;
        exp_lat = (s == 0) ? 3 : 1;
        req[s] = 1'b1; wr[s] = w; ad[s] = a; wd[s] = d;
        lat = 0; st = 0; ok = 1'b0;
        while (lat < 40 && !ok) begin
            #1;
            if (stl[s]) st++;
            @(posedge clk); #1;
            lat++;
            if (rdy[s]) ok = 1'b1;
            else if (drop) begin
                req[s] = 1'b0; wr[s] = 1'($urandom); ad[s] = $urandom; wd[s] = $urandom;
            end
        end
        if (!ok) begin
            n_chk++; n_err++;
            $display("FAIL handshake_timeout: no memready after %0d cycles, expected %0d", lat, exp_lat);
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("stall_cycles", 32'(st), 32'(exp_lat));
        chk("stall_in_done", 32'(stl[s]), 32'd0);
        r  = rd[s];
        mi = mis[s];
        idx = int'(a[7:2]);
        mal = (a[1:0] != 2'b00);
        chk("misaligned", 32'(mi), 32'(mal));
        if (w) begin
            if (!mal) begin
                m_mem[s][idx] = d; m_known[s][idx] = 1'b1; m_wc[s]++;
            end
        end else if (mal) begin
            m_rd[s] = 32'd0; m_rdk[s] = 1'b1;
        end else begin
            m_rd[s] = m_mem[s][idx]; m_rdk[s] = m_known[s][idx]; m_rc[s]++;
        end
        if (m_rdk[s]) chk("readdata", r, m_rd[s]);
        req[s] = 1'b0;
        @(posedge clk); #1;
        chk("ready_pulse_width", 32'(rdy[s]), 32'd0);
        chk("rdcount", rc[s], ecnt(m_rc[s]));
        chk("wrcount", wc[s], ecnt(m_wc[s]));
    endtask

    initial begin
        logic [31:0] r;
        bit          mi;
        logic [31:0] a;

        tbl[0] = '{1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0,        1'b0};
        tbl[1] = '{1'b0, 32'h10,  32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
        tbl[2] = '{1'b0, 32'h13,  32'h0,        1'b1, 32'h0,        1'b1};
        tbl[3] = '{1'b1, 32'h12,  32'hCAFEF00D, 1'b1, 32'h0,        1'b1};
        tbl[4] = '{1'b0, 32'h10,  32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
        tbl[5] = '{1'b1, 32'h100, 32'h77,       1'b1, 32'hDEADBEEF, 1'b0};
        tbl[6] = '{1'b0, 32'h0,   32'h0,        1'b1, 32'h77,       1'b0};
        tbl[7] = '{1'b1, 32'h8,   32'h11111111, 1'b0, 32'h0,        1'b0};
        tbl[8] = '{1'b0, 32'h8,   32'h0,        1'b1, 32'h11111111, 1'b0};

        for (int s = 0; s < 2; s++) begin
            req[s] = 1'b0; wr[s] = 1'b0; ad[s] = '0; wd[s] = '0; rst[s] = 1'b1;
            for (int i = 0; i < 64; i++) m_known[s][i] = 1'b0;
        end
        #2;
        for (int s = 0; s < 2; s++) do_reset(s);

        for (int s = 0; s < 2; s++) begin
            chk("reset_readdata",   rd[s],          32'd0);
            chk("reset_memready",   32'(rdy[s]),    32'd0);
            chk("reset_memstall",   32'(stl[s]),    32'd0);
            chk("reset_misaligned", 32'(mis[s]),    32'd0);
            chk("reset_rdcount",    rc[s],          32'd0);
            chk("reset_wrcount",    wc[s],          32'd0);
        end

        for (int i = 0; i < 9; i++) begin
            op(0, tbl[i].w, tbl[i].a, tbl[i].d, 1'b0, r, mi);
            chk("tbl_misaligned", 32'(mi), 32'(tbl[i].em));
            if (tbl[i].ck) chk("tbl_readdata", r, tbl[i].er);
        end

        // Request dropped while BUSY still completes.
        op(0, 1'b0, 32'h10, 32'h0, 1'b1, r, mi);
        chk("drop_readdata", r, 32'hDEADBEEF);

        // Reset in the middle of a store abandons it.
        req[0] = 1'b1; wr[0] = 1'b1; ad[0] = 32'h8; wd[0] = 32'h99;
        #1; chk("mid_stall_idle", 32'(stl[0]), 32'd1);
        @(posedge clk); #1;
        chk("mid_stall_busy", 32'(stl[0]), 32'd1);
        req[0] = 1'b0;
        rst[0] = 1'b1;
        #1;
        chk("mid_rst_stall", 32'(stl[0]), 32'd0);
        chk("mid_rst_ready", 32'(rdy[0]), 32'd0);
        chk("mid_rst_readdata", rd[0], 32'd0);
        @(posedge clk); #1;
        rst[0] = 1'b0;
        m_rc[0] = 0; m_wc[0] = 0; m_rd[0] = 32'd0; m_rdk[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("mid_rst_no_ready", 32'(rdy[0]), 32'd0);
        end
        op(0, 1'b0, 32'h8, 32'h0, 1'b0, r, mi);
        chk("mid_rst_prior_value", r, 32'h11111111);

        // Zero wait states, plus counter scenario: 3 loads, 2 stores, 1 misaligned load.
        do_reset(1);
        op(1, 1'b1, 32'h4,  32'h5,  1'b0, r, mi);
        op(1, 1'b0, 32'h4,  32'h0,  1'b0, r, mi);
        chk("ws0_readdata", r, 32'h5);
        op(1, 1'b1, 32'h20, 32'hAB, 1'b0, r, mi);
        op(1, 1'b0, 32'h20, 32'h0,  1'b0, r, mi);
        op(1, 1'b0, 32'h4,  32'h0,  1'b0, r, mi);
        op(1, 1'b0, 32'h3,  32'h0,  1'b0, r, mi);
        chk("ws0_misaligned_rd", r, 32'h0);
`ifdef DMEM_PERF_CNT_EN
        chk("perf_rdcount", rc[1], 32'd3);
        chk("perf_wrcount", wc[1], 32'd2);
`else
        chk("perf_rdcount_off", rc[1], 32'd0);
        chk("perf_wrcount_off", wc[1], 32'd0);
`endif

        for (int s = 0; s < 2; s++) begin
            for (int n = 0; n < 150; n++) begin
                if ($urandom_range(0, 39) == 0) do_reset(s);
                a = $urandom;
                if ($urandom_range(0, 5) != 0) a[1:0] = 2'b00;
                op(s, 1'($urandom), a, $urandom, 1'($urandom), r, mi);
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
